// File: rtl/net_blk_writer.sv
// net_blk_writer: packs a 64-bit valid/ready/last/keep beat stream into
// 66-bit blocks (64-bit payload + 2-bit sync header) and writes them
// directly into the network FIFO write port, gated by the FIFO full flag.
// Each frame is emitted as start block, data blocks, terminate block.
//
// Optional feature macro: NET_WR_IFG_EN
//   When defined, every terminate write is followed by IFG_CYCLES idle
//   cycles (START state) before the next start block may be written.

module net_blk_writer #(
    parameter int DWIDTH     = 64,
    parameter int CWIDTH     = 2,
    parameter int IFG_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DWIDTH-1:0] s_data,
    input  logic [7:0]        s_keep,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              full,
    output logic              wr,
    output logic [DWIDTH-1:0] w_data_d,
    output logic [CWIDTH-1:0] w_data_c,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        TERM0 = 2'd3
    } state_t;

    localparam logic [CWIDTH-1:0] SYNC_DATA = 2'b10;
    localparam logic [CWIDTH-1:0] SYNC_CTRL = 2'b01;
    localparam logic [DWIDTH-1:0] START_BLK = 64'hD555_5555_5555_5578;
    localparam logic [DWIDTH-1:0] TERM0_BLK = 64'h0000_0000_0000_0087;

    // Terminate type code for a final block carrying n payload bytes.
    function automatic logic [7:0] term_type(input logic [3:0] n);
        case (n)
            4'd0:    term_type = 8'h87;
            4'd1:    term_type = 8'h99;
            4'd2:    term_type = 8'hAA;
            4'd3:    term_type = 8'hB4;
            4'd4:    term_type = 8'hCC;
            4'd5:    term_type = 8'hD2;
            4'd6:    term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
    endfunction

    state_t      state_q, state_d, after_term;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]  keep_cnt;
    logic [DWIDTH-1:0] term_blk;
    logic        term_wr;

`ifdef NET_WR_IFG_EN
    logic [7:0] ifg_cnt_q, ifg_cnt_d;
    assign after_term = (IFG_CYCLES == 0) ? IDLE : START;
`else
    assign after_term = IDLE;
`endif

    assign keep_cnt  = 4'($countones(s_keep));
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

    // Build the short terminate block: type in [7:0], bytes 0..n-1 above it.
    always_comb begin
        term_blk      = '0;
        term_blk[7:0] = term_type(keep_cnt);
        for (int k = 0; k < 7; k++) begin
            if (k < int'(keep_cnt)) begin
                term_blk[8*(k+1) +: 8] = s_data[8*k +: 8];
            end
        end
    end

    // Next-state, FIFO write and beat-accept decode (zero-cycle latency).
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        s_ready     = 1'b0;
        wr          = 1'b0;
        w_data_d    = '0;
        w_data_c    = '0;
        term_wr     = 1'b0;
`ifdef NET_WR_IFG_EN
        ifg_cnt_d   = ifg_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Start block does not consume the beat; it is accepted in DATA.
                if (s_valid && !full) begin
                    wr       = 1'b1;
                    w_data_c = SYNC_CTRL;
                    w_data_d = START_BLK;
                    state_d  = DATA;
                end
            end
            START: begin
`ifdef NET_WR_IFG_EN
                ifg_cnt_d = ifg_cnt_q - 8'd1;
                if (ifg_cnt_d == 8'd0) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            DATA: begin
                s_ready = !full;
                if (s_valid && !full) begin
                    wr = 1'b1;
                    if (!s_last || keep_cnt == 4'd8) begin
                        w_data_c = SYNC_DATA;
                        w_data_d = s_data;
                        if (s_last) begin
                            state_d = TERM0;
                        end
                    end else begin
                        w_data_c = SYNC_CTRL;
                        w_data_d = term_blk;
                        term_wr  = 1'b1;
                        state_d  = after_term;
                    end
                end
            end
            TERM0: begin
                if (!full) begin
                    wr       = 1'b1;
                    w_data_c = SYNC_CTRL;
                    w_data_d = TERM0_BLK;
                    term_wr  = 1'b1;
                    state_d  = after_term;
                end
            end
            default: state_d = IDLE;
        endcase

        if (term_wr) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef NET_WR_IFG_EN
            ifg_cnt_d   = 8'(IFG_CYCLES);
`endif
        end

        // Nothing leaves the block while reset is held.
        if (!reset_n) begin
            wr      = 1'b0;
            s_ready = 1'b0;
        end
    end

    // State and frame counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
`ifdef NET_WR_IFG_EN
            ifg_cnt_q   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its _d value from before this edge.
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef NET_WR_IFG_EN
            ifg_cnt_q   <= ifg_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_net_blk_writer.sv
// tb_net_blk_writer: directed and randomized frames against a frame-level
// reference model; every FIFO write is captured and compared in order.

module tb_net_blk_writer;

    logic        clk;
    logic        reset_n;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        full;
    logic        wr;
    logic [63:0] w_data_d;
    logic [1:0]  w_data_c;
    logic        busy;
    logic [15:0] frame_cnt;

    net_blk_writer #(.DWIDTH(64), .CWIDTH(2), .IFG_CYCLES(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .full      (full),
        .wr        (wr),
        .w_data_d  (w_data_d),
        .w_data_c  (w_data_c),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [65:0] blk_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          full_wr  = 0;
    blk_t        exp_q[$];
    blk_t        obs_q[$];
    int          obs_cyc[$];
    logic [63:0] fb[$];
    logic [7:0]  fkeep;
    logic [15:0] exp_frames;

    always @(posedge clk) cyc++;

    // Capture every FIFO write away from the active edge.
    always @(negedge clk) begin
        if (wr) begin
            obs_q.push_back({w_data_c, w_data_d});
            obs_cyc.push_back(cyc);
            if (full) full_wr++;
        end
    end

    task automatic check(input string tag, input blk_t obs, input blk_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Frame-level model: what the FIFO must receive for the frame in fb.
    task automatic model_frame();
        logic [7:0]  bytes[8];
        logic [7:0]  types[8];
        logic [63:0] last;
        int          n;
        types = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        exp_q.push_back({2'b01, 64'hD555555555555578});
        for (int i = 0; i < fb.size() - 1; i++) exp_q.push_back({2'b10, fb[i]});
        last = fb[fb.size() - 1];
        n = $countones(fkeep);
        if (n == 8) begin
            exp_q.push_back({2'b10, last});
            exp_q.push_back({2'b01, 64'h87});
        end else begin
            foreach (bytes[k]) bytes[k] = 8'h00;
            bytes[0] = types[n];
            for (int k = 0; k < n; k++) bytes[k + 1] = last[8*k +: 8];
            exp_q.push_back({2'b01, bytes[7], bytes[6], bytes[5], bytes[4],
                             bytes[3], bytes[2], bytes[1], bytes[0]});
        end
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic new_frame(input int len, input logic [7:0] keep);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back({$urandom, $urandom});
        fkeep = keep;
    endtask

    // mode 0: no backpressure; 1: random valid gaps and full; 2: full held 5 cycles.
    task automatic send_frame(input int mode);
        int i = 0;
        int t = 0;
        while (i < fb.size() && t < 400) begin
            @(posedge clk); #1;
            s_data  = fb[i];
            s_last  = (i == fb.size() - 1);
            s_keep  = s_last ? fkeep : 8'($urandom);
            s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            full    = (mode == 1) ? ($urandom_range(0, 3) == 0)
                                  : (mode == 2 && t >= 2 && t < 7);
            @(negedge clk);
            if (mode == 2 && full) begin
                check("full_no_wr", wr, 0);
                check("full_no_ready", s_ready, 0);
            end
            if (s_valid && s_ready) i++;
            t++;
        end
        check("send_done", 32'(i), 32'(fb.size()));
        model_frame();
    endtask

    task automatic drain();
        @(posedge clk); #1;
        s_valid = 1'b0;
        full    = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_blk%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int gap;
        reset_n    = 1'b0;
        s_valid    = 1'b1;
        s_last     = 1'b0;
        s_keep     = 8'h00;
        s_data     = '0;
        full       = 1'b0;
        exp_frames = '0;

        // Reset state, with a valid beat presented.
        repeat (2) @(negedge clk);
        check("rst_wr", wr, 0);
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        s_valid = 1'b0;
        reset_n = 1'b1;

        // 3-beat frame, last keep 0x07.
        new_frame(3, 8'h07);
        fb[2] = 64'h0123_4567_89CC_CCCC;
        send_frame(0);
        drain();
        check("t1_term_literal", (obs_q.size() > 3) ? obs_q[3] : 'x,
              {2'b01, 64'h0000_0000_CCCC_CCB4});
        compare_all("t1");

        // 2-beat frame, last keep 0xFF -> trailing T0.
        new_frame(2, 8'hFF);
        send_frame(0);
        drain();
        compare_all("t2");

        // Single-beat frame, keep 0x01, byte 0x5A.
        new_frame(1, 8'h01);
        fb[0][7:0] = 8'h5A;
        send_frame(0);
        drain();
        check("t3_term_literal", (obs_q.size() > 1) ? obs_q[1] : 'x,
              {2'b01, 64'h0000_0000_0000_5A99});
        compare_all("t3");

        // full held for 5 cycles mid-frame.
        new_frame(5, 8'h3F);
        send_frame(2);
        drain();
        compare_all("t4");

        // Reset pulsed after start + 1 data block.
        new_frame(4, 8'h0F);
        @(posedge clk); #1;
        s_data  = fb[0];
        s_last  = 1'b0;
        s_keep  = 8'hFF;
        s_valid = 1'b1;
        full    = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr", wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_writes", obs_q.size(), 2);
        s_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        exp_frames = '0;
        send_frame(0);
        drain();
        compare_all("t5");

        // Back-to-back frames: idle gap between terminate and next start.
        new_frame(1, 8'h03);
        send_frame(0);
        new_frame(1, 8'h07);
        send_frame(0);
        drain();
        gap = (obs_cyc.size() > 2) ? obs_cyc[2] - obs_cyc[1] - 1 : -1;
`ifdef NET_WR_IFG_EN
        check("ifg_gap", gap, 3);
`else
        check("ifg_gap", gap, 0);
`endif
        compare_all("t6");

        // Randomized frames with valid gaps, full bursts and arbitrary keep.
        for (int f = 0; f < 25; f++) begin
            new_frame($urandom_range(1, 6),
                      ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            send_frame(1);
        end
        drain();
        compare_all("rand");
        check("wr_while_full", full_wr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
